// File: rtl/pulse_to_level.sv
// ---------------------------------------------------------------------------
// pulse_to_level
//
// Pulse stretcher. Each accepted single-cycle request on P becomes a clean
// high level on L that lasts max(hold_len,1) cycles. Every level is followed
// by a low gap of at least max(gap_len,1) cycles, so a downstream edge
// detector sees exactly one rising edge per accepted request.
//
// One request can be held pending while a level or gap is in progress. A
// request that arrives while one is already pending is discarded and
// reported on drop. With RETRIGGER=1, a request during HOLD restarts the
// hold count and is not queued.
//
// Handshake: there is none. P is a bare pulse, sampled on every rising clk
// edge. busy tells the producer that a new request would be queued or
// dropped rather than started immediately. drop is the only loss indication.
//
// Parameters
//   CNT_W      width of the hold/gap counters and of the length inputs
//   RETRIGGER  1: P during HOLD reloads the hold count; 0: P is queued
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   P          request pulse
//   hold_len   level length in cycles (0 treated as 1)
//   gap_len    minimum low time in cycles (0 treated as 1)
//   L          stretched level, registered
//   busy       state != IDLE or a request is pending, registered
//   drop       one-cycle registered pulse: a request was lost
//   dbg_state  current FSM state (0 IDLE, 1 HOLD, 2 GAP)
// ---------------------------------------------------------------------------
module pulse_to_level #(
  parameter int CNT_W     = 8,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             P,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [CNT_W-1:0] gap_len,
  output logic             L,
  output logic             busy,
  output logic             drop,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pending, pending_n;
  logic             drop_n;

  logic             l_q, busy_q, drop_q;

  // Load values. A length of zero is promoted to one so the counter is
  // never loaded with zero and the decrement can never wrap.
  logic [CNT_W-1:0] hold_load;
  logic [CNT_W-1:0] gap_load;
  logic             cnt_last;

  assign hold_load = (hold_len == CNT_ZERO) ? CNT_ONE : hold_len;
  assign gap_load  = (gap_len  == CNT_ZERO) ? CNT_ONE : gap_len;
  assign cnt_last  = (cnt == CNT_ONE);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= CNT_ZERO;
      pending <= 1'b0;
      l_q     <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      // Outputs are registered from the next-state values so that they
      // line up with the state they describe without a combinational path
      // from state decode to the pins.
      l_q     <= (state_n == S_HOLD);
      busy_q  <= (state_n != S_IDLE) | pending_n;
      drop_q  <= drop_n;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    drop_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (P) begin
          state_n = S_HOLD;
          cnt_n   = hold_load;
        end
      end

      S_HOLD: begin
        if (P && RETRIGGER) begin
          // Reload wins over the exit on the final hold cycle.
          cnt_n = hold_load;
        end else begin
          if (P) begin
            if (pending) begin
              drop_n = 1'b1;
            end else begin
              pending_n = 1'b1;
            end
          end
          if (cnt_last) begin
            state_n = S_GAP;
            cnt_n   = gap_load;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end

      S_GAP: begin
        if (cnt_last) begin
          // A request on the final gap cycle starts the next level directly.
          // If one was already pending the two merge into that single level,
          // so nothing is queued and nothing is dropped.
          if (pending || P) begin
            state_n   = S_HOLD;
            cnt_n     = hold_load;
            pending_n = 1'b0;
          end else begin
            state_n = S_IDLE;
            cnt_n   = CNT_ZERO;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
          if (P) begin
            if (pending) begin
              drop_n = 1'b1;
            end else begin
              pending_n = 1'b1;
            end
          end
        end
      end

      default: begin
        // Unreachable encoding: return to a clean idle.
        state_n   = S_IDLE;
        cnt_n     = CNT_ZERO;
        pending_n = 1'b0;
      end
    endcase
  end

  assign L         = l_q;
  assign busy      = busy_q;
  assign drop      = drop_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pulse_to_level.sv
// ---------------------------------------------------------------------------
// tb_pulse_to_level
//
// Two instances share all inputs: dut0 with RETRIGGER=0 and dut1 with
// RETRIGGER=1. A vector table covers queued/dropped requests versus
// retrigger, zero lengths and a plain single pulse. Hand-written sequences
// cover the reset state, an asynchronous reset mid-HOLD, a request on the
// last GAP cycle and a hold_len change during HOLD.
//
// Timing: inputs are driven 1 ns after a rising edge; outputs are sampled
// 1 ns after the following rising edge. Table row i therefore holds P for
// cycle i and the {L,busy,drop} expected in cycle i+1.
// ---------------------------------------------------------------------------
module tb_pulse_to_level;

  localparam int CNT_W = 8;

  // ---- clock / reset -------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             P;
  logic [CNT_W-1:0] hold_len;
  logic [CNT_W-1:0] gap_len;

  always #5 clk = ~clk;

  logic       l0, busy0, drop0;
  logic       l1, busy1, drop1;
  logic [1:0] st0, st1;

  pulse_to_level #(.CNT_W(CNT_W), .RETRIGGER(1'b0)) dut0 (
    .clk(clk), .reset(reset), .P(P), .hold_len(hold_len), .gap_len(gap_len),
    .L(l0), .busy(busy0), .drop(drop0), .dbg_state(st0)
  );

  pulse_to_level #(.CNT_W(CNT_W), .RETRIGGER(1'b1)) dut1 (
    .clk(clk), .reset(reset), .P(P), .hold_len(hold_len), .gap_len(gap_len),
    .L(l1), .busy(busy1), .drop(drop1), .dbg_state(st1)
  );

  // ---- scoreboard ----------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- driver tasks --------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] g);
    P        = p;
    hold_len = h;
    gap_len  = g;
  endtask

  // ---- vector table --------------------------------------------------------
  typedef struct {
    logic             p;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] gap;
    logic [2:0]       exp0;   // {L,busy,drop} of dut0 in the next cycle
    logic [2:0]       exp1;   // {L,busy,drop} of dut1 in the next cycle
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  initial begin
    // hold=4 gap=2, P at cycles 0,2,3. dut0 queues then drops; dut1 retriggers.
    vecs[0]  = '{1'b1, 8'd4, 8'd2, 3'b110, 3'b110};
    vecs[1]  = '{1'b0, 8'd4, 8'd2, 3'b110, 3'b110};
    vecs[2]  = '{1'b1, 8'd4, 8'd2, 3'b110, 3'b110};
    vecs[3]  = '{1'b1, 8'd4, 8'd2, 3'b111, 3'b110};
    vecs[4]  = '{1'b0, 8'd4, 8'd2, 3'b010, 3'b110};
    vecs[5]  = '{1'b0, 8'd4, 8'd2, 3'b010, 3'b110};
    vecs[6]  = '{1'b0, 8'd4, 8'd2, 3'b110, 3'b110};
    vecs[7]  = '{1'b0, 8'd4, 8'd2, 3'b110, 3'b010};
    vecs[8]  = '{1'b0, 8'd4, 8'd2, 3'b110, 3'b010};
    vecs[9]  = '{1'b0, 8'd4, 8'd2, 3'b110, 3'b000};
    vecs[10] = '{1'b0, 8'd4, 8'd2, 3'b010, 3'b000};
    vecs[11] = '{1'b0, 8'd4, 8'd2, 3'b010, 3'b000};
    vecs[12] = '{1'b0, 8'd4, 8'd2, 3'b000, 3'b000};
    // hold=0 gap=0, P every other cycle: one high cycle per pulse.
    vecs[13] = '{1'b1, 8'd0, 8'd0, 3'b110, 3'b110};
    vecs[14] = '{1'b0, 8'd0, 8'd0, 3'b010, 3'b010};
    vecs[15] = '{1'b1, 8'd0, 8'd0, 3'b110, 3'b110};
    vecs[16] = '{1'b0, 8'd0, 8'd0, 3'b010, 3'b010};
    vecs[17] = '{1'b1, 8'd0, 8'd0, 3'b110, 3'b110};
    vecs[18] = '{1'b0, 8'd0, 8'd0, 3'b010, 3'b010};
    vecs[19] = '{1'b0, 8'd0, 8'd0, 3'b000, 3'b000};
    // hold=3 gap=2, single P: 3 high cycles, busy clears 2 cycles later.
    vecs[20] = '{1'b1, 8'd3, 8'd2, 3'b110, 3'b110};
    vecs[21] = '{1'b0, 8'd3, 8'd2, 3'b110, 3'b110};
    vecs[22] = '{1'b0, 8'd3, 8'd2, 3'b110, 3'b110};
    vecs[23] = '{1'b0, 8'd3, 8'd2, 3'b010, 3'b010};
    vecs[24] = '{1'b0, 8'd3, 8'd2, 3'b010, 3'b010};
    vecs[25] = '{1'b0, 8'd3, 8'd2, 3'b000, 3'b000};
  end

  // ---- test sequence -------------------------------------------------------
  initial begin
    reset = 1'b1;
    drive(1'b0, 8'd0, 8'd0);
    repeat (3) step();

    // Reset state
    check("rst_out0", {5'd0, l0, busy0, drop0}, 8'd0);
    check("rst_out1", {5'd0, l1, busy1, drop1}, 8'd0);
    check("rst_state0", {6'd0, st0}, 8'd0);
    check("rst_state1", {6'd0, st1}, 8'd0);

    reset = 1'b0;
    step();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].p, vecs[i].hold, vecs[i].gap);
      exp_q.push_back(vecs[i].exp0);
      exp_q.push_back(vecs[i].exp1);
      step();
      check($sformatf("vec%0d_dut0", i), {5'd0, l0, busy0, drop0}, {5'd0, exp_q.pop_front()});
      check($sformatf("vec%0d_dut1", i), {5'd0, l1, busy1, drop1}, {5'd0, exp_q.pop_front()});
    end

    // Asynchronous reset in the middle of HOLD (hold=5)
    drive(1'b1, 8'd5, 8'd2);
    step();
    drive(1'b0, 8'd5, 8'd2);
    step();
    step();
    check("async_pre_L", {7'd0, l0}, 8'd1);
    #3 reset = 1'b1;
    #1;
    check("async_L0", {6'd0, l0, busy0}, 8'd0);
    check("async_L1", {6'd0, l1, busy1}, 8'd0);
    check("async_state", {6'd0, st0}, 8'd0);
    step();
    reset = 1'b0;
    step();
    // Normal 5-cycle level after release
    drive(1'b1, 8'd5, 8'd2);
    step();
    drive(1'b0, 8'd5, 8'd2);
    begin
      int highs = 0;
      for (int i = 0; i < 9; i++) begin
        if (l0) highs++;
        step();
      end
      check("post_rst_len", 8'(highs), 8'd5);
    end
    check("post_rst_idle", {6'd0, l0, busy0}, 8'd0);

    // Request on the last GAP cycle; hold_len change during HOLD
    drive(1'b1, 8'd2, 8'd3);
    step();                                 // HOLD cnt2
    drive(1'b0, 8'd2, 8'd3);
    step();                                 // HOLD cnt1
    step();                                 // GAP cnt3
    step();                                 // GAP cnt2
    step();                                 // GAP cnt1
    check("gap_last_pre", {6'd0, l0, busy0}, 8'b01);
    drive(1'b1, 8'd2, 8'd3);
    step();                                 // HOLD cnt2
    check("gap_last_hold", {5'd0, l0, busy0, drop0}, 8'b110);
    check("gap_last_st", {6'd0, st0}, 8'd1);
    drive(1'b0, 8'd7, 8'd3);                // change hold_len mid-run
    step();                                 // HOLD cnt1
    check("hold_len_fixed1", {5'd0, l0, busy0, drop0}, 8'b110);
    step();                                 // GAP cnt3
    check("hold_len_fixed2", {5'd0, l0, busy0, drop0}, 8'b010);
    step();
    step();
    step();                                 // IDLE: nothing was queued
    check("gap_last_idle", {5'd0, l0, busy0, drop0}, 8'b000);
    check("gap_last_idle1", {5'd0, l1, busy1, drop1}, 8'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
